// File: rtl/wb_stage.sv
// Write-back stage: result selection, load alignment, HI/LO registers,
// register-file write port, trace outputs and retirement counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stall,
    input  logic        wreg,
    input  logic        whi,
    input  logic        wlo,
    input  logic        hi_i_sel,
    input  logic        lo_i_sel,
    input  logic [1:0]  result_sel,
    input  logic        hilo_rsel,
    input  logic        SC_result_sel,
    input  logic [3:0]  load_type,
    input  logic [31:0] ALU_result,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] rf_rdata0_fw,
    input  logic [31:0] rf_rdata1_fw,
    input  logic [31:0] PC_plus4,
    input  logic [63:0] MulDiv_result,
    input  logic [4:0]  regdst,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] retire_cnt
);

    localparam int unsigned DW = 32;

    localparam logic [3:0] LT_LB  = 4'd1;
    localparam logic [3:0] LT_LBU = 4'd2;
    localparam logic [3:0] LT_LH  = 4'd3;
    localparam logic [3:0] LT_LHU = 4'd4;
    localparam logic [3:0] LT_LWL = 4'd6;
    localparam logic [3:0] LT_LWR = 4'd7;

    logic [1:0]    off;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] lwl_data;
    logic [DW-1:0] lwr_data;
    logic [DW-1:0] load_data;
    logic [DW-1:0] hilo_rdata;

    assign off = ALU_result[1:0];

    // Architectural write enable: suppressed by stall and by writes to $0.
    assign rf_we    = wreg & ~wb_stall & (regdst != 5'd0);
    assign rf_waddr = regdst;

    // Byte and halfword lane extraction by address offset (little-endian).
    always_comb begin
        ld_byte = mem_rdata[7:0];
        ld_half = mem_rdata[15:0];
        case (off)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        if (off[1]) begin
            ld_half = mem_rdata[31:16];
        end
    end

    // Unaligned-word merges: LWL fills the upper bytes, LWR the lower bytes.
    always_comb begin
        lwl_data = mem_rdata;
        lwr_data = mem_rdata;
        case (off)
            2'd0: begin
                lwl_data = {mem_rdata[7:0],  rf_rdata1_fw[23:0]};
                lwr_data = mem_rdata;
            end
            2'd1: begin
                lwl_data = {mem_rdata[15:0], rf_rdata1_fw[15:0]};
                lwr_data = {rf_rdata1_fw[31:24], mem_rdata[31:8]};
            end
            2'd2: begin
                lwl_data = {mem_rdata[23:0], rf_rdata1_fw[7:0]};
                lwr_data = {rf_rdata1_fw[31:16], mem_rdata[31:16]};
            end
            default: begin
                lwl_data = mem_rdata;
                lwr_data = {rf_rdata1_fw[31:8], mem_rdata[31:24]};
            end
        endcase
    end

    // Load result by type; none, LW and the unused codes pass the word through.
    always_comb begin
        load_data = mem_rdata;
        case (load_type)
            LT_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  load_data = {24'd0, ld_byte};
            LT_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  load_data = {16'd0, ld_half};
            LT_LWL:  load_data = lwl_data;
            LT_LWR:  load_data = lwr_data;
            default: load_data = mem_rdata;
        endcase
    end

    // HI/LO read always sees the registered value, never the same-cycle write.
    assign hilo_rdata = hilo_rsel ? hi_o : lo_o;

    // Final write data; SC status overrides every other source.
    always_comb begin
        rf_wdata = ALU_result;
        if (SC_result_sel) begin
            rf_wdata = {31'd0, ALU_result[0]};
        end else begin
            case (result_sel)
                2'b00:   rf_wdata = ALU_result;
                2'b01:   rf_wdata = load_data;
                2'b10:   rf_wdata = PC_plus4 + DW'(4);
                default: rf_wdata = hilo_rdata;
            endcase
        end
    end

    // Trace port mirrors the architectural write.
    assign debug_wb_pc       = PC_plus4 - DW'(4);
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // HI/LO registers, written independently unless stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else begin
            if (~wb_stall & whi) begin
                hi_o <= hi_i_sel ? rf_rdata0_fw : MulDiv_result[63:32];
            end
            if (~wb_stall & wlo) begin
                lo_o <= lo_i_sel ? rf_rdata0_fw : MulDiv_result[31:0];
            end
        end
    end

    // Retirement counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (rf_we) begin
            retire_cnt <= retire_cnt + DW'(1);
        end
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port wb_stall, input, 1 bit: WB stall; when high, no architectural write occurs.
REQ-004 SHALL have ports wreg, whi, wlo, input, 1 bit each: write enables from the MEM/WB register.
REQ-005 SHALL have ports hi_i_sel and lo_i_sel, input, 1 bit each: 0 = MulDiv_result half, 1 = rf_rdata0_fw.
REQ-006 SHALL have port result_sel, input, 2 bits: 00 ALU_result, 01 load data, 10 PC_plus4+4, 11 HI/LO read.
REQ-007 SHALL have port hilo_rsel, input, 1 bit: HI/LO read source, 0 = LO, 1 = HI.
REQ-008 SHALL have port SC_result_sel, input, 1 bit: when high, the write data is {31'b0, ALU_result[0]}.
REQ-009 SHALL have port load_type, input, 4 bits: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8-15 treated as LW.
REQ-010 SHALL have ports ALU_result, mem_rdata, rf_rdata0_fw, rf_rdata1_fw, PC_plus4, input, 32 bits each.
REQ-011 SHALL have port MulDiv_result, input, 64 bits: {hi, lo}.
REQ-012 SHALL have port regdst, input, 5 bits: destination register.
REQ-013 SHALL have ports rf_we (output, 1 bit), rf_waddr (output, 5 bits) and rf_wdata (output, 32 bits): register-file write port, combinational.
REQ-014 SHALL have ports hi_o and lo_o, output, 32 bits each: registered HI/LO values.
REQ-015 SHALL have ports debug_wb_pc (output, 32 bits), debug_wb_rf_wen (output, 4 bits), debug_wb_rf_wnum (output, 5 bits) and debug_wb_rf_wdata (output, 32 bits): trace outputs.
REQ-016 SHALL have port retire_cnt, output, 32 bits: count of WB cycles with rf_we high.

Function
REQ-017 SHALL drive rf_we = wreg & ~wb_stall & (regdst != 0).
REQ-018 SHALL drive rf_waddr = regdst.
REQ-019 SHALL take the load offset from ALU_result[1:0] (little-endian).
REQ-020 SHALL select the source byte for LB/LBU as mem_rdata[8*off+7:8*off], sign-extended for LB and zero-extended for LBU.
REQ-021 SHALL select the source half for LH/LHU as mem_rdata[16*off[1]+15:16*off[1]], sign-extended for LH and zero-extended for LHU; off[0] is ignored.
REQ-022 SHALL form the LWL result per MIPS32 by merging memory bytes 0..off into rf_rdata1_fw bytes 3-off..3.
REQ-023 SHALL form the LWR result per MIPS32 by merging memory bytes off..3 into rf_rdata1_fw bytes 0..3-off.
REQ-024 SHALL give SC_result_sel priority over result_sel.
REQ-025 SHALL compute the PC_plus4+4 link value modulo 2^32.
REQ-026 SHALL, on a clock edge where ~wb_stall & whi, load HI from MulDiv_result[63:32] or rf_rdata0_fw per hi_i_sel; LO SHALL update likewise under wlo.
REQ-027 SHALL update HI and LO independently when whi and wlo are asserted in the same cycle.
REQ-028 SHALL, when result_sel is 11, read the pre-edge register value for HI/LO, with no same-cycle bypass.
REQ-029 SHALL drive debug_wb_pc = PC_plus4 - 4.
REQ-030 SHALL drive debug_wb_rf_wen = {4{rf_we}}, debug_wb_rf_wnum = rf_waddr and debug_wb_rf_wdata = rf_wdata.
REQ-031 SHALL increment retire_cnt by 1 on each edge with rf_we high and wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 SHALL, on rst assertion, immediately clear hi_o, lo_o and retire_cnt to 0, independent of clk.
REQ-033 SHALL, during reset, leave the combinational outputs following their inputs; no state update occurs while rst is high.
REQ-034 SHALL resume normal updates on the first rising edge after rst deasserts.

Verification
REQ-035 SHALL cover: load_type=1, ALU_result[1:0]=2, mem_rdata=0x12F45678 -> rf_wdata=0xFFFFFFF4; with load_type=2 -> 0x000000F4.
REQ-036 SHALL cover: load_type=6, off=1, mem_rdata=0xAABBCCDD, rf_rdata1_fw=0x11223344 -> 0xCCDD3344; load_type=7, off=1 -> 0x11AABBCC.
REQ-037 SHALL cover: whi=wlo=1, sels=0, MulDiv_result=0x00000001_FFFFFFFE -> the next cycle hi_o=1, lo_o=0xFFFFFFFE; then result_sel=11, hilo_rsel=1 -> rf_wdata=1.
REQ-038 SHALL cover: wb_stall=1 with wreg=whi=1 -> rf_we=0, HI unchanged, retire_cnt unchanged.
REQ-039 SHALL cover: wreg=1, regdst=0 -> rf_we=0; regdst=31, result_sel=10, PC_plus4=0xBFC00004 -> rf_wdata=0xBFC00008, debug_wb_pc=0xBFC00000.
REQ-040 SHALL cover: rst pulsed between clock edges with hi_o=5 -> hi_o=0 before the next edge; retire_cnt forced to 0xFFFFFFFF (via writes) then one retire -> 0.
